// File: rtl/rv_id_ex_reg.sv
// ID/EX pipeline register for the RV64 core: valid/ready handshake, flush, and load-use bubbles.
// Optional feature macro: RV_LOAD_USE_DETECT_EN enables the in-stage load-use hazard interlock.
module rv_id_ex_reg #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            id_valid_i,
    output logic            id_ready_o,
    input  logic            ex_ready_i,
    input  logic            flush_i,
    input  logic            branch_i,
    input  logic            mem_read_i,
    input  logic            mem_to_reg_i,
    input  logic            mem_write_i,
    input  logic            alu2_src_i,
    input  logic            reg_write_i,
    input  logic            jal_i,
    input  logic            jalr_i,
    input  logic [1:0]      alu1_src_i,
    input  logic [1:0]      reg_read_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    input  logic [4:0]      rd_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    output logic            ex_valid_o,
    output logic            branch_o,
    output logic            mem_read_o,
    output logic            mem_to_reg_o,
    output logic            mem_write_o,
    output logic            alu2_src_o,
    output logic            reg_write_o,
    output logic            jal_o,
    output logic            jalr_o,
    output logic [1:0]      alu1_src_o,
    output logic [1:0]      reg_read_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic            load_use_o
);

    localparam int CW = 12;

    logic [CW-1:0]   ctrl_in_s;
    logic [CW-1:0]   ctrl_r;
    logic            ex_valid_r;
    logic            hz_s;
    logic            stall_s;
    logic            accept_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] rs1_data_r;
    logic [XLEN-1:0] rs2_data_r;
    logic [XLEN-1:0] imm_r;
    logic [4:0]      rs1_r;
    logic [4:0]      rs2_r;
    logic [4:0]      rd_r;
    logic [2:0]      funct3_r;
    logic [6:0]      funct7_r;

    assign ctrl_in_s = {branch_i, mem_read_i, mem_to_reg_i, mem_write_i, alu2_src_i,
                        reg_write_i, jal_i, jalr_i, alu1_src_i, reg_read_i};

`ifdef RV_LOAD_USE_DETECT_EN
    // Load in EX whose destination is read by the instruction waiting in ID.
    always_comb begin
        hz_s = 1'b0;
        if (ex_valid_r && ctrl_r[10] && (rd_r != 5'd0) && id_valid_i) begin
            if ((reg_read_i[0] && (rs1_i == rd_r)) || (reg_read_i[1] && (rs2_i == rd_r))) begin
                hz_s = 1'b1;
            end else begin
                hz_s = 1'b0;
            end
        end else begin
            hz_s = 1'b0;
        end
    end
`else
    assign hz_s = 1'b0;
`endif

    assign stall_s    = ex_valid_r & ~ex_ready_i;
    // Flush always frees ID, so the redirected-away instruction is dropped upstream too.
    assign id_ready_o = flush_i | (~stall_s & ~hz_s);
    assign accept_s   = id_valid_i & ~flush_i & ~stall_s & ~hz_s;
    assign load_use_o = hz_s;

    // Valid flag and control bundle: flush > stall > hazard bubble > accept > idle bubble.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid_r <= 1'b0;
            ctrl_r     <= {CW{1'b0}};
        end else if (flush_i) begin
            ex_valid_r <= 1'b0;
            ctrl_r     <= {CW{1'b0}};
        end else if (stall_s) begin
            ex_valid_r <= ex_valid_r;
            ctrl_r     <= ctrl_r;
        end else if (accept_s) begin
            ex_valid_r <= 1'b1;
            ctrl_r     <= ctrl_in_s;
        end else begin
            ex_valid_r <= 1'b0;
            ctrl_r     <= {CW{1'b0}};
        end
    end

    // Data fields only move on an accepted instruction; bubbles keep the stale payload.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_r       <= {XLEN{1'b0}};
            rs1_data_r <= {XLEN{1'b0}};
            rs2_data_r <= {XLEN{1'b0}};
            imm_r      <= {XLEN{1'b0}};
            rs1_r      <= 5'd0;
            rs2_r      <= 5'd0;
            rd_r       <= 5'd0;
            funct3_r   <= 3'd0;
            funct7_r   <= 7'd0;
        end else if (accept_s) begin
            pc_r       <= pc_i;
            rs1_data_r <= rs1_data_i;
            rs2_data_r <= rs2_data_i;
            imm_r      <= imm_i;
            rs1_r      <= rs1_i;
            rs2_r      <= rs2_i;
            rd_r       <= rd_i;
            funct3_r   <= funct3_i;
            funct7_r   <= funct7_i;
        end else begin
            pc_r       <= pc_r;
            rs1_data_r <= rs1_data_r;
            rs2_data_r <= rs2_data_r;
            imm_r      <= imm_r;
            rs1_r      <= rs1_r;
            rs2_r      <= rs2_r;
            rd_r       <= rd_r;
            funct3_r   <= funct3_r;
            funct7_r   <= funct7_r;
        end
    end

    assign ex_valid_o   = ex_valid_r;
    assign branch_o     = ctrl_r[11];
    assign mem_read_o   = ctrl_r[10];
    assign mem_to_reg_o = ctrl_r[9];
    assign mem_write_o  = ctrl_r[8];
    assign alu2_src_o   = ctrl_r[7];
    assign reg_write_o  = ctrl_r[6];
    assign jal_o        = ctrl_r[5];
    assign jalr_o       = ctrl_r[4];
    assign alu1_src_o   = ctrl_r[3:2];
    assign reg_read_o   = ctrl_r[1:0];
    assign pc_o         = pc_r;
    assign rs1_data_o   = rs1_data_r;
    assign rs2_data_o   = rs2_data_r;
    assign imm_o        = imm_r;
    assign rs1_o        = rs1_r;
    assign rs2_o        = rs2_r;
    assign rd_o         = rd_r;
    assign funct3_o     = funct3_r;
    assign funct7_o     = funct7_r;

endmodule

// File: tb/tb_rv_id_ex_reg.sv
// Directed self-checking bench for rv_id_ex_reg; expectations follow RV_LOAD_USE_DETECT_EN.
module tb_rv_id_ex_reg;

    logic        clk;
    logic        rstn;
    logic        id_valid_i, id_ready_o, ex_ready_i, flush_i;
    logic        branch_i, mem_read_i, mem_to_reg_i, mem_write_i, alu2_src_i, reg_write_i, jal_i, jalr_i;
    logic [1:0]  alu1_src_i, reg_read_i;
    logic [63:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [4:0]  rs1_i, rs2_i, rd_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic        ex_valid_o;
    logic        branch_o, mem_read_o, mem_to_reg_o, mem_write_o, alu2_src_o, reg_write_o, jal_o, jalr_o;
    logic [1:0]  alu1_src_o, reg_read_o;
    logic [63:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    logic        load_use_o;

    int errors = 0;
    int checks = 0;

`ifdef RV_LOAD_USE_DETECT_EN
    localparam bit HZ_EN = 1'b1;
`else
    localparam bit HZ_EN = 1'b0;
`endif

    rv_id_ex_reg #(.XLEN(64)) dut (
        .clk(clk), .rstn(rstn),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .ex_ready_i(ex_ready_i), .flush_i(flush_i),
        .branch_i(branch_i), .mem_read_i(mem_read_i), .mem_to_reg_i(mem_to_reg_i),
        .mem_write_i(mem_write_i), .alu2_src_i(alu2_src_i), .reg_write_i(reg_write_i),
        .jal_i(jal_i), .jalr_i(jalr_i), .alu1_src_i(alu1_src_i), .reg_read_i(reg_read_i),
        .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
        .ex_valid_o(ex_valid_o),
        .branch_o(branch_o), .mem_read_o(mem_read_o), .mem_to_reg_o(mem_to_reg_o),
        .mem_write_o(mem_write_o), .alu2_src_o(alu2_src_o), .reg_write_o(reg_write_o),
        .jal_o(jal_o), .jalr_o(jalr_o), .alu1_src_o(alu1_src_o), .reg_read_o(reg_read_o),
        .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
        .load_use_o(load_use_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction in ID; data fields derive from pc so each is distinct.
    task automatic drive(input logic v, input logic [63:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [1:0] rr, input logic mr, input logic rw,
                         input logic [1:0] a1);
        id_valid_i   = v;
        pc_i         = pc;
        rs1_data_i   = pc ^ 64'hFFFF_0000_0000_0000;
        rs2_data_i   = pc + 64'd1;
        imm_i        = {pc[31:0], 32'h0000_0000};
        rs1_i        = rs1;
        rs2_i        = rs2;
        rd_i         = rd;
        reg_read_i   = rr;
        mem_read_i   = mr;
        mem_to_reg_i = mr;
        reg_write_i  = rw;
        alu1_src_i   = a1;
        alu2_src_i   = mr;
        branch_i     = 1'b0;
        mem_write_i  = 1'b0;
        jal_i        = 1'b0;
        jalr_i       = 1'b0;
        funct3_i     = pc[4:2];
        funct7_i     = 7'h20;
    endtask

    initial begin
        rstn = 1'b0;
        ex_ready_i = 1'b1;
        flush_i = 1'b0;
        drive(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'b00);
        #12;
        chk("rst_valid", ex_valid_o, 64'd0);
        chk("rst_pc", pc_o, 64'd0);
        chk("rst_lu", load_use_o, 64'd0);
        chk("rst_ready", id_ready_o, 64'd1);
        rstn = 1'b1;

        // ADD x3,x1,x2 at 0x100, one-cycle latency
        drive(1'b1, 64'h100, 5'd1, 5'd2, 5'd3, 2'b11, 1'b0, 1'b1, 2'b00);
        #1;
        chk("add_ready", id_ready_o, 64'd1);
        step();
        chk("add_valid", ex_valid_o, 64'd1);
        chk("add_pc", pc_o, 64'h100);
        chk("add_rw", reg_write_o, 64'd1);
        chk("add_rd", rd_o, 64'd3);
        chk("add_rr", reg_read_o, 64'd3);
        chk("add_rs1d", rs1_data_o, 64'hFFFF_0000_0000_0100);
        chk("add_rs2d", rs2_data_o, 64'h101);
        chk("add_imm", imm_o, 64'h0000_0100_0000_0000);
        chk("add_f7", funct7_o, 64'h20);

        // back-pressure for 3 cycles with next instruction waiting
        drive(1'b1, 64'h104, 5'd3, 5'd3, 5'd4, 2'b01, 1'b0, 1'b1, 2'b10);
        ex_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", id_ready_o, 64'd0);
            step();
            chk("bp_valid", ex_valid_o, 64'd1);
            chk("bp_pc", pc_o, 64'h100);
            chk("bp_a1", alu1_src_o, 64'd0);
        end
        ex_ready_i = 1'b1;
        #1;
        chk("bp_release_ready", id_ready_o, 64'd1);
        step();
        chk("bp_next_pc", pc_o, 64'h104);
        chk("bp_next_rd", rd_o, 64'd4);
        chk("bp_next_a1", alu1_src_o, 64'd2);
        chk("bp_next_f3", funct3_o, 64'd1);

        // load-use: LD x5 then ADD x6,x5,x7
        drive(1'b1, 64'h108, 5'd1, 5'd0, 5'd5, 2'b01, 1'b1, 1'b1, 2'b00);
        step();
        chk("ld_mr", mem_read_o, 64'd1);
        chk("ld_m2r", mem_to_reg_o, 64'd1);
        drive(1'b1, 64'h10C, 5'd5, 5'd7, 5'd6, 2'b11, 1'b0, 1'b1, 2'b00);
        #1;
        chk("lu_flag", load_use_o, HZ_EN ? 64'd1 : 64'd0);
        chk("lu_ready", id_ready_o, HZ_EN ? 64'd0 : 64'd1);
        step();
        if (HZ_EN) begin
            chk("lu_bubble_valid", ex_valid_o, 64'd0);
            chk("lu_bubble_rw", reg_write_o, 64'd0);
            chk("lu_bubble_mr", mem_read_o, 64'd0);
            chk("lu_bubble_pc_hold", pc_o, 64'h108);
            chk("lu_after_flag", load_use_o, 64'd0);
            chk("lu_after_ready", id_ready_o, 64'd1);
            step();
        end
        chk("lu_add_valid", ex_valid_o, 64'd1);
        chk("lu_add_pc", pc_o, 64'h10C);
        chk("lu_add_rd", rd_o, 64'd6);

        // idle bubble: controls cleared, data held
        drive(1'b0, 64'h1F0, 5'd9, 5'd9, 5'd9, 2'b11, 1'b1, 1'b1, 2'b11);
        step();
        chk("idle_valid", ex_valid_o, 64'd0);
        chk("idle_rw", reg_write_o, 64'd0);
        chk("idle_rr", reg_read_o, 64'd0);
        chk("idle_pc_hold", pc_o, 64'h10C);

        // LD x0 then user of x0: no stall
        drive(1'b1, 64'h200, 5'd1, 5'd0, 5'd0, 2'b01, 1'b1, 1'b1, 2'b00);
        step();
        drive(1'b1, 64'h204, 5'd0, 5'd0, 5'd6, 2'b11, 1'b0, 1'b1, 2'b00);
        #1;
        chk("x0_lu", load_use_o, 64'd0);
        chk("x0_ready", id_ready_o, 64'd1);
        step();
        chk("x0_pc", pc_o, 64'h204);

        // LD x5 then LUI (no sources read)
        drive(1'b1, 64'h208, 5'd1, 5'd0, 5'd5, 2'b01, 1'b1, 1'b1, 2'b00);
        step();
        drive(1'b1, 64'h20C, 5'd5, 5'd5, 5'd8, 2'b00, 1'b0, 1'b1, 2'b01);
        #1;
        chk("lui_lu", load_use_o, 64'd0);
        step();
        chk("lui_pc", pc_o, 64'h20C);

        // LD x7 then ADDI x6,x5 (rs2 field matches but is unused)
        drive(1'b1, 64'h210, 5'd1, 5'd0, 5'd7, 2'b01, 1'b1, 1'b1, 2'b00);
        step();
        drive(1'b1, 64'h214, 5'd5, 5'd7, 5'd6, 2'b01, 1'b0, 1'b1, 2'b00);
        #1;
        chk("addi_lu", load_use_o, 64'd0);
        step();
        chk("addi_pc", pc_o, 64'h214);

        // flush with hazard and EX stall at the same time
        drive(1'b1, 64'h300, 5'd1, 5'd0, 5'd5, 2'b01, 1'b1, 1'b1, 2'b00);
        step();
        drive(1'b1, 64'h304, 5'd5, 5'd7, 5'd6, 2'b11, 1'b0, 1'b1, 2'b00);
        ex_ready_i = 1'b0;
        flush_i = 1'b1;
        #1;
        chk("fl_ready", id_ready_o, 64'd1);
        step();
        chk("fl_valid", ex_valid_o, 64'd0);
        chk("fl_mr", mem_read_o, 64'd0);
        chk("fl_rw", reg_write_o, 64'd0);
        chk("fl_pc_hold", pc_o, 64'h300);
        flush_i = 1'b0;
        chk("fl_lu_after", load_use_o, 64'd0);

        // empty stage accepts even while EX is not ready
        drive(1'b1, 64'h308, 5'd2, 5'd3, 5'd4, 2'b11, 1'b0, 1'b1, 2'b00);
        #1;
        chk("empty_ready", id_ready_o, 64'd1);
        step();
        chk("empty_valid", ex_valid_o, 64'd1);
        chk("empty_pc", pc_o, 64'h308);

        // asynchronous reset mid-stream
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid", ex_valid_o, 64'd0);
        chk("arst_pc", pc_o, 64'd0);
        chk("arst_rw", reg_write_o, 64'd0);
        chk("arst_rd", rd_o, 64'd0);
        rstn = 1'b1;
        ex_ready_i = 1'b1;
        drive(1'b1, 64'h400, 5'd1, 5'd2, 5'd3, 2'b11, 1'b0, 1'b1, 2'b00);
        step();
        chk("post_rst_valid", ex_valid_o, 64'd1);
        chk("post_rst_pc", pc_o, 64'h400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
